m_reg_read: RTL and testbench

//  Register-read/issue stage directly downstream of the register-field decoder.

---
 rtl/m_reg_read_if.sv | 44 ++++
 rtl/m_reg_read.sv | 107 ++++++++++
 tb/tb_m_reg_read.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/m_reg_read_if.sv
// Issue-stage bus: decoder input, execute output, and writeback/flush from execute.
interface m_reg_read_if #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs;
  logic [4:0]           in_rq;
  logic                 in_rd_we;
  logic [PAYLOAD_W-1:0] in_payload;

  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           out_rd;
  logic                 out_rd_we;
  logic [XLEN-1:0]      out_rs_val;
  logic [XLEN-1:0]      out_rq_val;
  logic [PAYLOAD_W-1:0] out_payload;

  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 flush;

  // Stage side
  modport slave (
    input  in_valid, in_rd, in_rs, in_rq, in_rd_we, in_payload,
    output in_ready,
    output out_valid, out_rd, out_rd_we, out_rs_val, out_rq_val, out_payload,
    input  out_ready,
    input  wb_valid, wb_rd, wb_data, flush
  );

  // Decoder / execute side
  modport master (
    output in_valid, in_rd, in_rs, in_rq, in_rd_we, in_payload,
    input  in_ready,
    input  out_valid, out_rd, out_rd_we, out_rs_val, out_rq_val, out_payload,
    output out_ready,
    output wb_valid, wb_rd, wb_data, flush
  );
endinterface

// File: rtl/m_reg_read.sv
// Register read / issue stage: regfile read, per-register scoreboard hazard
// stall, one-entry output register toward execute, writeback port.
module m_reg_read #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 32,
  parameter int BYPASS    = 1
) (
  input logic          clk,
  input logic          rst_n,
  m_reg_read_if.slave  bus
);

  logic [31:0][XLEN-1:0] rf;
  logic [31:0]           sb, sb_nxt;

  logic                  vld_q;
  logic [4:0]            rd_q;
  logic                  rd_we_q;
  logic [XLEN-1:0]       rs_val_q, rq_val_q;
  logic [PAYLOAD_W-1:0]  pay_q;

  logic                  hazard, accept, wb_en, flush_clr;
  logic [XLEN-1:0]       rs_val, rq_val;

  // Same-cycle writeback that can be forwarded to index idx
  function automatic logic byp_hit(input logic [4:0] idx, input logic v, input logic [4:0] wr);
    return (BYPASS != 0) && v && (wr == idx);
  endfunction

  // Register still waiting on an in-flight writer (a forwarded writeback resolves it)
  function automatic logic pend(input logic [31:0] s, input logic [4:0] idx,
                                input logic v, input logic [4:0] wr);
    return s[idx] && (idx != 5'd0) && !byp_hit(idx, v, wr);
  endfunction

  assign wb_en     = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign flush_clr = bus.flush && vld_q && rd_we_q && (rd_q != 5'd0);

  // RAW on either source, WAW on the destination
  assign hazard = pend(sb, bus.in_rs, bus.wb_valid, bus.wb_rd)
                | pend(sb, bus.in_rq, bus.wb_valid, bus.wb_rd)
                | (bus.in_rd_we & pend(sb, bus.in_rd, bus.wb_valid, bus.wb_rd));

  assign bus.in_ready = !hazard && !bus.flush && (!vld_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Operand select: r0 is hardwired zero, then forwarded writeback, then regfile
  always_comb begin
    rs_val = rf[bus.in_rs];
    rq_val = rf[bus.in_rq];
    if (byp_hit(bus.in_rs, bus.wb_valid, bus.wb_rd)) rs_val = bus.wb_data;
    if (byp_hit(bus.in_rq, bus.wb_valid, bus.wb_rd)) rq_val = bus.wb_data;
    if (bus.in_rs == 5'd0) rs_val = '0;
    if (bus.in_rq == 5'd0) rq_val = '0;
  end

  // Scoreboard next state: clears first so a new accept's set wins on the same bit
  always_comb begin
    sb_nxt = sb;
    if (wb_en)     sb_nxt[bus.wb_rd] = 1'b0;
    if (flush_clr) sb_nxt[rd_q]      = 1'b0;
    if (accept && bus.in_rd_we && (bus.in_rd != 5'd0)) sb_nxt[bus.in_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  // Register file and scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= '0;
      sb <= '0;
    end else begin
      if (wb_en) rf[bus.wb_rd] <= bus.wb_data;
      sb <= sb_nxt;
    end
  end

  // Output register: flush beats handshake; accept reloads, otherwise drain on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      rd_q     <= '0;
      rd_we_q  <= 1'b0;
      rs_val_q <= '0;
      rq_val_q <= '0;
      pay_q    <= '0;
    end else if (bus.flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q    <= 1'b1;
      rd_q     <= bus.in_rd;
      rd_we_q  <= bus.in_rd_we;
      rs_val_q <= rs_val;
      rq_val_q <= rq_val;
      pay_q    <= bus.in_payload;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rd_we   = rd_we_q;
  assign bus.out_rs_val  = rs_val_q;
  assign bus.out_rq_val  = rq_val_q;
  assign bus.out_payload = pay_q;

endmodule

// File: tb/tb_m_reg_read.sv
// Directed bench: one BYPASS=1 instance for the main sequence, one BYPASS=0
// instance for the non-forwarding stall case.
module tb_m_reg_read;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  m_reg_read_if #(.XLEN(32), .PAYLOAD_W(32)) b1 ();
  m_reg_read_if #(.XLEN(32), .PAYLOAD_W(32)) b0 ();

  m_reg_read #(.XLEN(32), .PAYLOAD_W(32), .BYPASS(1)) u_b1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  m_reg_read #(.XLEN(32), .PAYLOAD_W(32), .BYPASS(0)) u_b0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    b1.in_valid = 0; b1.in_rd = 0; b1.in_rs = 0; b1.in_rq = 0; b1.in_rd_we = 0; b1.in_payload = 0;
    b1.out_ready = 1; b1.wb_valid = 0; b1.wb_rd = 0; b1.wb_data = 0; b1.flush = 0;
    b0.in_valid = 0; b0.in_rd = 0; b0.in_rs = 0; b0.in_rq = 0; b0.in_rd_we = 0; b0.in_payload = 0;
    b0.out_ready = 1; b0.wb_valid = 0; b0.wb_rd = 0; b0.wb_data = 0; b0.flush = 0;

    // reset state
    repeat (2) tick();
    chk("rst_out_valid",   b1.out_valid, 0);
    chk("rst_out_rs_val",  b1.out_rs_val, 0);
    chk("rst_out_payload", b1.out_payload, 0);
    chk("rst_in_ready",    b1.in_ready, 1);
    rst_n = 1'b1;
    tick();

    // writebacks then issue rs=5, rq=6
    b1.wb_valid = 1; b1.wb_rd = 5; b1.wb_data = 32'h11; tick();
    b1.wb_rd = 6; b1.wb_data = 32'h22; tick();
    b1.wb_valid = 0;
    b1.in_valid = 1; b1.in_rs = 5; b1.in_rq = 6; b1.in_rd = 1; b1.in_rd_we = 0; b1.in_payload = 32'hA1;
    #1 chk("t1_in_ready", b1.in_ready, 1);
    tick();
    chk("t1_out_valid",  b1.out_valid, 1);
    chk("t1_rs_val",     b1.out_rs_val, 32'h11);
    chk("t1_rq_val",     b1.out_rq_val, 32'h22);
    chk("t1_payload",    b1.out_payload, 32'hA1);

    // RAW on r7 resolved by forwarded writeback
    b1.in_rd = 7; b1.in_rd_we = 1; b1.in_rs = 0; b1.in_rq = 0; b1.in_payload = 32'hB1;
    tick();
    chk("t2_out_rd",    b1.out_rd, 7);
    chk("t2_out_rd_we", b1.out_rd_we, 1);
    b1.in_rd = 0; b1.in_rd_we = 0; b1.in_rs = 7; b1.in_payload = 32'hB2;
    #1 chk("t2_stall0", b1.in_ready, 0);
    tick();
    #1 chk("t2_stall1", b1.in_ready, 0);
    b1.wb_valid = 1; b1.wb_rd = 7; b1.wb_data = 32'hAB;
    #1 chk("t2_bypass_ready", b1.in_ready, 1);
    tick();
    b1.wb_valid = 0; b1.in_valid = 0;
    chk("t2_out_valid", b1.out_valid, 1);
    chk("t2_rs_val",    b1.out_rs_val, 32'hAB);
    chk("t2_payload",   b1.out_payload, 32'hB2);
    tick();

    // backpressure: output held stable, then back-to-back
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_rs = 5; b1.in_rq = 6; b1.in_rd = 0; b1.in_rd_we = 0; b1.in_payload = 32'hC1;
    tick();
    chk("t3_payload_c1", b1.out_payload, 32'hC1);
    b1.in_rs = 6; b1.in_rq = 5; b1.in_payload = 32'hC2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_ready",   b1.in_ready, 0);
      chk("t3_hold_valid",   b1.out_valid, 1);
      chk("t3_hold_payload", b1.out_payload, 32'hC1);
      chk("t3_hold_rs",      b1.out_rs_val, 32'h11);
      tick();
    end
    b1.out_ready = 1;
    #1 chk("t3_b2b_ready", b1.in_ready, 1);
    tick();
    chk("t3_b2b_valid",   b1.out_valid, 1);
    chk("t3_b2b_payload", b1.out_payload, 32'hC2);
    chk("t3_b2b_rs",      b1.out_rs_val, 32'h22);
    chk("t3_b2b_rq",      b1.out_rq_val, 32'h11);
    b1.in_valid = 0;
    tick();
    chk("t3_drain", b1.out_valid, 0);

    // r0: never pending, always reads zero
    b1.in_valid = 1; b1.in_rd = 0; b1.in_rd_we = 1; b1.in_rs = 0; b1.in_rq = 0; b1.in_payload = 32'hD1;
    tick();
    b1.in_rd_we = 0; b1.in_payload = 32'hD2;
    #1 chk("t4_no_stall", b1.in_ready, 1);
    tick();
    chk("t4_payload", b1.out_payload, 32'hD2);
    chk("t4_rs_val",  b1.out_rs_val, 0);
    b1.in_valid = 0;
    b1.wb_valid = 1; b1.wb_rd = 0; b1.wb_data = 32'hFF;
    tick();
    b1.wb_valid = 0;
    b1.in_valid = 1; b1.in_rs = 0; b1.in_rq = 5; b1.in_payload = 32'hD3;
    tick();
    chk("t4_r0_after_wb", b1.out_rs_val, 0);
    chk("t4_rq_val",      b1.out_rq_val, 32'h11);
    chk("t4_payload3",    b1.out_payload, 32'hD3);
    b1.in_valid = 0;
    tick();

    // flush releases the pending destination
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_rd = 9; b1.in_rd_we = 1; b1.in_rs = 0; b1.in_rq = 0; b1.in_payload = 32'hE1;
    tick();
    chk("t5_out_valid", b1.out_valid, 1);
    chk("t5_out_rd",    b1.out_rd, 9);
    b1.in_rd = 0; b1.in_rd_we = 0; b1.in_rs = 9; b1.in_payload = 32'hE2;
    #1 chk("t5_raw_stall", b1.in_ready, 0);
    b1.flush = 1;
    #1 chk("t5_flush_ready", b1.in_ready, 0);
    tick();
    b1.flush = 0;
    chk("t5_flushed", b1.out_valid, 0);
    #1 chk("t5_sb_cleared", b1.in_ready, 1);
    tick();
    chk("t5_accept_valid",   b1.out_valid, 1);
    chk("t5_accept_payload", b1.out_payload, 32'hE2);
    chk("t5_accept_rs",      b1.out_rs_val, 0);
    b1.in_valid = 0;

    // asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",   b1.out_valid, 0);
    chk("t6_rst_payload", b1.out_payload, 0);
    tick();
    rst_n = 1'b1;
    b1.out_ready = 1;
    b1.in_valid = 1; b1.in_rs = 5; b1.in_rq = 6; b1.in_payload = 32'h61;
    tick();
    chk("t6_rf_cleared_rs", b1.out_rs_val, 0);
    chk("t6_rf_cleared_rq", b1.out_rq_val, 0);
    b1.in_valid = 0;
    tick();

    // BYPASS=0: accepted one cycle after writeback, value from regfile
    b0.in_valid = 1; b0.in_rd = 7; b0.in_rd_we = 1; b0.in_rs = 0; b0.in_rq = 0; b0.in_payload = 32'hF1;
    tick();
    b0.in_rd = 0; b0.in_rd_we = 0; b0.in_rs = 7; b0.in_payload = 32'hF2;
    #1 chk("t7_stall0", b0.in_ready, 0);
    tick();
    b0.wb_valid = 1; b0.wb_rd = 7; b0.wb_data = 32'hAB;
    #1 chk("t7_no_bypass", b0.in_ready, 0);
    tick();
    b0.wb_valid = 0;
    #1 chk("t7_ready_after_wb", b0.in_ready, 1);
    tick();
    chk("t7_out_valid", b0.out_valid, 1);
    chk("t7_rs_val",    b0.out_rs_val, 32'hAB);
    chk("t7_payload",   b0.out_payload, 32'hF2);
    b0.in_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
